// File: rtl/gray_rx.sv
// Receiver for a 3-bit Gray-coded counter: decodes samples, checks that
// each step is a hold or a single forward step, and counts wraps.
module gray_rx (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       In_Valid,
  input  logic [2:0] Gray_In,
  input  logic       Clear,
  output logic [2:0] Bin_Out,
  output logic       Out_Valid,
  output logic       Wrap,
  output logic [3:0] Wrap_Cnt,
  output logic       Step_Err,
  output logic       Locked
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t     r_state     = UNLOCKED;
  logic [2:0] r_prev      = 3'b000;
  logic [2:0] r_bin       = 3'b000;
  logic       r_out_valid = 1'b0;
  logic       r_wrap      = 1'b0;
  logic [3:0] r_wrap_cnt  = 4'd0;
  logic       r_step_err  = 1'b0;

  function automatic logic [2:0] g2b(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  logic [2:0] w_bin_in;
  logic [2:0] w_bin_prev;
  logic [2:0] w_bin_next;
  logic       w_hold;
  logic       w_succ;
  logic       w_wrap;

  assign w_bin_in   = g2b(Gray_In);
  assign w_bin_prev = g2b(r_prev);
  assign w_bin_next = w_bin_prev + 3'd1;
  assign w_hold     = (Gray_In == r_prev);
  assign w_succ     = (w_bin_in == w_bin_next);
  // Legal forward step from the last code (100) back to the first (000)
  assign w_wrap     = w_succ && (r_prev == 3'b100);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= UNLOCKED;
      r_prev      <= 3'b000;
      r_bin       <= 3'b000;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_wrap_cnt  <= 4'd0;
      r_step_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
      if (Clear) begin
        r_step_err <= 1'b0;
        r_state    <= UNLOCKED;
      end else if (In_Valid) begin
        r_out_valid <= 1'b1;
        r_bin       <= w_bin_in;
        unique case (r_state)
          UNLOCKED: begin
            r_prev  <= Gray_In;
            r_state <= LOCKED;
          end
          LOCKED: begin
            if (w_hold) begin
              r_prev <= r_prev;
            end else if (w_succ) begin
              r_prev <= Gray_In;
              if (w_wrap) begin
                r_wrap <= 1'b1;
                if (r_wrap_cnt != 4'd15)
                  r_wrap_cnt <= r_wrap_cnt + 4'd1;
              end
            end else begin
              r_step_err <= 1'b1;
              r_state    <= ERROR;
            end
          end
          ERROR: begin
            r_step_err <= 1'b1;
          end
          default: begin
            r_state <= UNLOCKED;
          end
        endcase
      end
    end
  end

  assign Bin_Out   = r_bin;
  assign Out_Valid = r_out_valid;
  assign Wrap      = r_wrap;
  assign Wrap_Cnt  = r_wrap_cnt;
  assign Step_Err  = r_step_err;
  assign Locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_gray_rx.sv
// Scoreboard bench for gray_rx: a table-driven model pushes the expected
// output vector per cycle; each test pops and compares after the edge.
module tb_gray_rx;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       In_Valid = 1'b0;
  logic [2:0] Gray_In = 3'b000;
  logic       Clear = 1'b0;
  logic [2:0] Bin_Out;
  logic       Out_Valid;
  logic       Wrap;
  logic [3:0] Wrap_Cnt;
  logic       Step_Err;
  logic       Locked;

  gray_rx dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .Gray_In(Gray_In),
    .Clear(Clear), .Bin_Out(Bin_Out), .Out_Valid(Out_Valid), .Wrap(Wrap),
    .Wrap_Cnt(Wrap_Cnt), .Step_Err(Step_Err), .Locked(Locked)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                          3'b110, 3'b111, 3'b101, 3'b100};

  // {Bin_Out, Out_Valid, Wrap, Wrap_Cnt, Step_Err, Locked}
  logic [10:0] sb [$];
  logic [10:0] e;

  int m_state = 0;
  int m_prev = 0;
  int m_bin = 0;
  int m_cnt = 0;
  bit m_err = 0;

  function automatic int idx(input logic [2:0] g);
    for (int i = 0; i < 8; i++)
      if (seq[i] == g) return i;
    return 0;
  endfunction

  function automatic logic [10:0] obs();
    return {Bin_Out, Out_Valid, Wrap, Wrap_Cnt, Step_Err, Locked};
  endfunction

  task automatic step(input bit r, input bit c, input bit v, input logic [2:0] g);
    bit ov;
    bit wr;
    int k;
    ov = 0;
    wr = 0;
    k = idx(g);
    if (r) begin
      m_state = 0; m_prev = 0; m_bin = 0; m_cnt = 0; m_err = 0;
    end else if (c) begin
      m_err = 0; m_state = 0;
    end else if (v) begin
      ov = 1;
      m_bin = k;
      if (m_state == 0) begin
        m_prev = k; m_state = 1;
      end else if (m_state == 1) begin
        if (k == m_prev) begin
          m_prev = k;
        end else if (k == (m_prev + 1) % 8) begin
          if (m_prev == 7) begin
            wr = 1;
            if (m_cnt < 15) m_cnt++;
          end
          m_prev = k;
        end else begin
          m_err = 1; m_state = 2;
        end
      end
    end
    sb.push_back({3'(m_bin), ov, wr, 4'(m_cnt), m_err, m_state == 1});
    Reset = r; Clear = c; In_Valid = v; Gray_In = g;
    @(posedge Clk);
    #1;
    Reset = 0; Clear = 0; In_Valid = 0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (obs() !== 11'd0) begin
      n_bad++;
      $display("FAIL powerup: got %h want %h", obs(), 11'd0);
    end
    step(1, 0, 0, 3'b000);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || e !== 11'd0) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL walk[%0d]: got %h want %h", i, obs(), e);
      end
      n_cmp++;
      if (Bin_Out !== 3'(i) || Locked !== 1'b1 || Step_Err !== 1'b0) begin
        n_bad++;
        $display("FAIL walk_bin[%0d]: got %0d/%b want %0d/1", i, Bin_Out, Locked, i);
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 3'b000);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Wrap !== 1'b1 || Wrap_Cnt !== 4'd1 || Bin_Out !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap1: got %h want %h", obs(), e);
    end
    step(0, 0, 0, 3'b000);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_pulse: got %h want %h", obs(), e);
    end
    for (int c = 0; c < 16; c++) begin
      for (int i = 1; i <= 8; i++) begin
        step(0, 0, 1, seq[i % 8]);
        e = sb.pop_front();
        n_cmp++;
        if (obs() !== e) begin
          n_bad++;
          $display("FAIL wrap_loop[%0d.%0d]: got %h want %h", c, i, obs(), e);
        end
      end
    end
    n_cmp++;
    if (Wrap_Cnt !== 4'd15 || Wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_sat: got cnt %0d wrap %b want 15 1", Wrap_Cnt, Wrap);
    end
  endtask

  task automatic test_illegal();
    step(0, 0, 1, 3'b001);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL ill_pre: got %h want %h", obs(), e);
    end
    step(0, 0, 1, 3'b110);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Step_Err !== 1'b1 || Bin_Out !== 3'd4 || Locked !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_step: got %h want %h", obs(), e);
    end
    step(0, 0, 1, 3'b011);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Step_Err !== 1'b1 || Wrap_Cnt !== 4'd15 || Bin_Out !== 3'd2) begin
      n_bad++;
      $display("FAIL ill_after: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_clear();
    step(0, 1, 1, 3'b010);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Step_Err !== 1'b0 || Out_Valid !== 1'b0 || Locked !== 1'b0) begin
      n_bad++;
      $display("FAIL clear: got %h want %h", obs(), e);
    end
    step(0, 0, 1, 3'b111);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Bin_Out !== 3'd5 || Step_Err !== 1'b0 || Locked !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_relock: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_hold();
    step(1, 0, 0, 3'b000);
    void'(sb.pop_front());
    step(0, 0, 1, 3'b000);
    void'(sb.pop_front());
    step(0, 0, 1, 3'b001);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      step(0, 0, (i % 2) == 0, 3'b011);
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e || Bin_Out !== 3'd2 || Out_Valid !== ((i % 2) == 0) || Step_Err) begin
        n_bad++;
        $display("FAIL hold[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_prio();
    step(0, 0, 1, 3'b010);
    void'(sb.pop_front());
    step(0, 0, 1, 3'b000);
    void'(sb.pop_front());
    step(1, 1, 1, 3'b010);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || obs() !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_prio: got %h want %h", obs(), e);
    end
    step(0, 0, 1, 3'b101);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Bin_Out !== 3'd6 || Step_Err !== 1'b0 || Locked !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_relock: got %h want %h", obs(), e);
    end
    step(0, 0, 1, 3'b000);
    e = sb.pop_front();
    n_cmp++;
    if (obs() !== e || Step_Err !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_skip: got %h want %h", obs(), e);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_walk();
    test_wrap();
    test_illegal();
    test_clear();
    test_hold();
    test_reset_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
